// File: rtl/pattern_resp_pkg.sv
// pattern_resp_pkg: shared FSM states, MISR polynomial taps and seed for the response compactor.
package pattern_resp_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int SIG_W_DEF = 16;
  localparam logic [SIG_W_DEF-1:0] MISR_TAPS = 16'hB400;
  localparam logic [SIG_W_DEF-1:0] SIG_SEED = 16'h0001;
endpackage

// File: rtl/pattern_misr.sv
// pattern_misr: multiple-input signature register, Fibonacci feedback from TAPS, response XORed into the low bits.
module pattern_misr
  import pattern_resp_pkg::*;
#(
  parameter int SIG_W = SIG_W_DEF,
  parameter int RESP_W = 11,
  parameter logic [SIG_W-1:0] TAPS = SIG_W'(MISR_TAPS),
  parameter logic [SIG_W-1:0] SEED = SIG_W'(SIG_SEED)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load_seed,
  input  logic              i_shift_en,
  input  logic [RESP_W-1:0] i_data,
  output logic [SIG_W-1:0]  o_sig
);
  always_ff @(posedge clk)
    if (rst) o_sig <= '0;
    else if (i_load_seed) o_sig <= SEED;
    else if (i_shift_en) o_sig <= {o_sig[SIG_W-2:0], ^(o_sig & TAPS)} ^ SIG_W'(i_data);
endmodule

// File: rtl/pattern_resp_compactor.sv
// pattern_resp_compactor: start/busy/done window that compacts num_samples response vectors into a MISR signature.
// Define RESP_TOGGLE_CNT_EN to add the saturating toggle_cnt output.
module pattern_resp_compactor
  import pattern_resp_pkg::*;
#(
  parameter int RESP_W = 11,
  parameter int SIG_W = SIG_W_DEF,
  parameter int CNT_W = 16
) (
  input  logic              blif_clk_net,
  input  logic              blif_reset_net,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_samples,
  input  logic              resp_valid,
  input  logic [RESP_W-1:0] resp_data,
  output logic              busy,
  output logic              done,
  output logic [SIG_W-1:0]  signature,
  output logic [CNT_W-1:0]  sample_cnt
`ifdef RESP_TOGGLE_CNT_EN
  ,
  output logic [CNT_W-1:0]  toggle_cnt
`endif
);
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_num, r_cnt;
  logic w_go, w_accept, w_last;
  assign w_go = (r_state == IDLE) && start;
  assign w_accept = (r_state == RUN) && resp_valid;
  assign w_last = w_accept && (r_cnt + CNT_W'(1) == r_num);
  assign busy = r_state != IDLE;
  assign done = r_state == DONE;
  assign sample_cnt = r_cnt;
  always_ff @(posedge blif_clk_net)
    if (blif_reset_net) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (w_go) w_next = (num_samples == '0) ? DONE : RUN;
    else if (w_last) w_next = DONE;
    else if (r_state == DONE) w_next = IDLE;
  end
  always_ff @(posedge blif_clk_net)
    if (blif_reset_net) begin
      r_num <= '0;
      r_cnt <= '0;
    end else if (w_go) begin
      r_num <= num_samples;
      r_cnt <= '0;
    end else if (w_accept) r_cnt <= r_cnt + CNT_W'(1);
  pattern_misr #(.SIG_W(SIG_W), .RESP_W(RESP_W)) u_misr (
    .clk(blif_clk_net),
    .rst(blif_reset_net),
    .i_load_seed(w_go),
    .i_shift_en(w_accept),
    .i_data(resp_data),
    .o_sig(signature)
  );
`ifdef RESP_TOGGLE_CNT_EN
  logic [RESP_W-1:0] r_prev;
  logic [CNT_W-1:0] r_toggle;
  logic [CNT_W:0] w_sum;
  assign w_sum = {1'b0, r_toggle} + (CNT_W+1)'($countones(resp_data ^ r_prev));
  assign toggle_cnt = r_toggle;
  always_ff @(posedge blif_clk_net)
    if (blif_reset_net) begin
      r_prev <= '0;
      r_toggle <= '0;
    end else if (w_go) begin
      r_prev <= '0;
      r_toggle <= '0;
    end else if (w_accept) begin
      r_prev <= resp_data;
      r_toggle <= w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
    end
`endif
endmodule

// File: tb/tb_pattern_resp_compactor.sv
// tb_pattern_resp_compactor: directed and randomized windows checked against a behavioural MISR/counter model.
module tb_pattern_resp_compactor;
  logic clk = 0, rst = 1, start = 0, resp_valid = 0;
  logic [15:0] num_samples = 0;
  logic [10:0] resp_data = 0;
  logic busy, done;
  logic [15:0] signature, sample_cnt;
`ifdef RESP_TOGGLE_CNT_EN
  logic [15:0] toggle_cnt;
`endif
  int n_checks = 0, n_fail = 0;
  logic [15:0] m_sig;
  int m_cnt, m_tog;
  always #5 clk = ~clk;
  pattern_resp_compactor dut (
    .blif_clk_net(clk),
    .blif_reset_net(rst),
    .start(start),
    .num_samples(num_samples),
    .resp_valid(resp_valid),
    .resp_data(resp_data),
    .busy(busy),
    .done(done),
    .signature(signature),
    .sample_cnt(sample_cnt)
`ifdef RESP_TOGGLE_CNT_EN
    ,
    .toggle_cnt(toggle_cnt)
`endif
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [10:0] d);
    int taps[4] = '{15, 13, 12, 10};
    logic fb = 0;
    foreach (taps[k]) fb ^= s[taps[k]];
    return {s[14:0], fb} ^ {5'd0, d};
  endfunction
  function automatic int popcount(input logic [10:0] v);
    int c = 0;
    for (int b = 0; b < 11; b++) c += int'(v[b]);
    return c;
  endfunction
  task automatic check_toggle(input string tag);
`ifdef RESP_TOGGLE_CNT_EN
    check(tag, toggle_cnt, m_tog);
`endif
  endtask
  task automatic run_seq(input int n, input logic [11:0] seq[$]);
    logic [10:0] pv = 0;
    m_sig = 16'h0001;
    m_cnt = 0;
    m_tog = 0;
    start = 1;
    num_samples = 16'(n);
    step();
    start = 0;
    check("busy_after_start", busy, 1);
    check("done_after_start", done, n == 0);
    foreach (seq[i]) begin
      if (m_cnt == n) break;
      resp_valid = seq[i][11];
      resp_data = seq[i][10:0];
      start = (i == 1);
      step();
      if (seq[i][11]) begin
        m_sig = misr_step(m_sig, seq[i][10:0]);
        m_tog = m_tog + popcount(seq[i][10:0] ^ pv);
        if (m_tog > 65535) m_tog = 65535;
        pv = seq[i][10:0];
        m_cnt++;
      end
      check("done_in_run", done, m_cnt == n);
      check("sig_in_run", signature, m_sig);
    end
    resp_valid = 0;
    start = 0;
    check("done_final", done, 1);
    check("sample_cnt", sample_cnt, m_cnt);
    check_toggle("toggle_cnt");
    step();
    check("done_one_cycle", done, 0);
    check("busy_idle", busy, 0);
    check("sig_hold", signature, m_sig);
  endtask
  initial begin
    logic [11:0] seq[$];
    int n, nv;
    step();
    step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sig", signature, 0);
    check("rst_cnt", sample_cnt, 0);
    check_toggle("rst_toggle");
    rst = 0;
    start = 1;
    num_samples = 10;
    step();
    start = 0;
    resp_valid = 1;
    repeat (3) begin
      resp_data = 11'($urandom);
      step();
    end
    check("mid_cnt", sample_cnt, 3);
    rst = 1;
    step();
    resp_valid = 0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sig", signature, 0);
    check("abort_cnt", sample_cnt, 0);
    rst = 0;
    step();
    check("abort_no_done", done, 0);
    seq = '{12'h800};
    run_seq(1, seq);
    check("one_zero_sig", signature, 16'h0002);
    check("one_zero_cnt", sample_cnt, 1);
    seq = '{12'hFFF};
    run_seq(1, seq);
    check("one_ones_sig", signature, 16'h07FD);
    seq.delete();
    run_seq(0, seq);
    check("zero_sig", signature, 16'h0001);
    check("zero_cnt", sample_cnt, 0);
    seq = '{12'h812, 12'h0FF, 12'h834, 12'hA56, 12'h777, 12'hC01};
    run_seq(4, seq);
    resp_valid = 1;
    repeat (3) begin
      resp_data = 11'($urandom);
      step();
      check("idle_valid_sig", signature, m_sig);
      check("idle_valid_cnt", sample_cnt, m_cnt);
    end
    resp_valid = 0;
`ifdef RESP_TOGGLE_CNT_EN
    seq = '{12'hFFF, 12'h800, 12'h801};
    run_seq(3, seq);
    check("toggle_23", toggle_cnt, 23);
`endif
    for (int k = 0; k < 25; k++) begin
      n = $urandom_range(0, 12);
      nv = 0;
      seq.delete();
      while (nv < n) begin
        logic v;
        v = $urandom_range(0, 99) < 70;
        seq.push_back({v, 11'($urandom)});
        if (v) nv++;
      end
      run_seq(n, seq);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
